regfile_writeback: RTL

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 45 ++++
 rtl/regfile_writeback.sv | 114 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared writeback types: register address/data widths, the zero register, and the {rd,data} entry.
// No logic, so no latency or backpressure of its own.
package wb_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry;
endpackage

// File: rtl/wb_fifo.sv
// Sync FIFO of wb_entry. A push lands at the next edge; the head is visible combinationally.
// A push while full and a pop while empty are ignored. Pointers carry an extra wrap bit.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_push,
    input  wb_entry i_push_dat,
    input  logic    i_pop,
    output wb_entry o_head_dat,
    output logic    o_full,
    output logic    o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    wb_entry     r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty    = (r_wptr == r_rptr);
    assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    // Storage is not reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
    end
endmodule

// File: rtl/regfile_writeback.sv
// Writeback arbiter: loads (priority) and buffered ALU results share one registered RF write port; tracks busy regs.
// Latency: load 1 cycle, ALU 2 cycles through the FIFO. alu_ready = FIFO not full; loads are never stalled.
// WB_BYPASS_EN adds byp_valid/byp_addr/byp_data showing the write selected this cycle, before the register.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int ALU_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] rgAddW,
    output logic [DATA_W-1:0]     dataW,
    output logic [NUM_REGS-1:0]   busy
`ifdef WB_BYPASS_EN
    ,
    output logic                  byp_valid,
    output logic [REG_ADDR_W-1:0] byp_addr,
    output logic [DATA_W-1:0]     byp_data
`endif
);
    wb_entry               w_head;
    wb_entry               w_sel;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_sel_vld;
    logic                  w_sel_wr;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic                  r_wen;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]     r_data;
    logic [NUM_REGS-1:0]   r_busy;

    assign alu_ready = !w_fifo_full;
    assign w_push    = alu_valid && alu_ready;
    assign w_pop     = !ld_valid && !w_fifo_empty;

    wb_fifo #(
        .DEPTH (ALU_FIFO_DEPTH)
    ) u_alu_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_push_dat ('{rd: alu_rd, data: alu_data}),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    always_comb begin
        w_sel_vld = 1'b0;
        w_sel     = '0;
        if (ld_valid) begin
            w_sel_vld = 1'b1;
            w_sel     = '{rd: ld_rd, data: ld_data};
        end else if (!w_fifo_empty) begin
            w_sel_vld = 1'b1;
            w_sel     = w_head;
        end
    end

    // A selected write to r0 is consumed (the FIFO still pops) but never reaches the port.
    assign w_sel_wr = w_sel_vld && (w_sel.rd != REG_ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_wen <= w_sel_wr;
            if (w_sel_wr) begin
                r_addr <= w_sel.rd;
                r_data <= w_sel.data;
            end
        end
    end

    // Clear first so a same-cycle issue to the retiring register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen) w_busy_nxt[r_addr] = 1'b0;
        if (issue_valid && (issue_rd != REG_ZERO)) w_busy_nxt[issue_rd] = 1'b1;
        w_busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    assign wen    = r_wen;
    assign rgAddW = r_addr;
    assign dataW  = r_data;
    assign busy   = r_busy;

`ifdef WB_BYPASS_EN
    assign byp_valid = w_sel_wr;
    assign byp_addr  = w_sel.rd;
    assign byp_data  = w_sel.data;
`endif
endmodule
